// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the CPU pipeline (master) and the
// iterative multiply/divide engine (slave).
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] High;
  logic [WIDTH-1:0] Low;
  logic             DivByZero;

  modport master (output Start, Op, A, B,
                  input  Busy, Done, High, Low, DivByZero);
  modport slave  (input  Start, Op, A, B,
                  output Busy, Done, High, Low, DivByZero);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO engine for MULT/MULTU/DIV/DIVU: magnitudes go through a
// radix-2 shift-add or restoring shift-subtract loop, and signs are fixed at the end.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   high_q, high_d, low_q, low_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  // Single iteration steps on the {upper, lower} accumulator
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [WIDTH-1:0]   div_rem;
  logic               div_qbit;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic               sa, sb, is_div, div_zero;

  assign is_div   = op_q[1];
  assign div_zero = is_div && (b_q == '0);
  assign sa       = op_q[0] & a_q[WIDTH-1];
  assign sb       = op_q[0] & b_q[WIDTH-1];

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Remainder shifted left with the next dividend bit; keep it if the subtract borrows
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, m_q};
  assign div_qbit  = ~div_trial[WIDTH];
  assign div_rem   = div_qbit ? div_trial[WIDTH-1:0]
                              : {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_qbit};

  assign prod_fix  = neg_lo_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    acc_d    = acc_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    high_d   = high_q;
    low_d    = low_q;
    case (state_q)
      S_IDLE: if (bus.Start) begin
        op_d    = bus.Op;
        a_d     = bus.A;
        b_d     = bus.B;
        state_d = S_PREP;
      end
      S_PREP: begin
        m_d      = sb ? -b_q : b_q;
        acc_d    = {{WIDTH{1'b0}}, (sa ? -a_q : a_q)};
        neg_lo_d = sa ^ sb;
        neg_hi_d = sa;
        cnt_d    = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (!is_div) begin
          high_d = prod_fix[2*WIDTH-1:WIDTH];
          low_d  = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
          high_d = a_q;
          low_d  = '1;
        end else begin
          high_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          low_d  = neg_lo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered decodes of the upcoming state
  always_comb begin
    busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
    dbz_d  = (state_d == S_DONE) && div_zero;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      high_q   <= high_d;
      low_q    <= low_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.High      = high_q;
  assign bus.Low       = low_q;
  assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases, random
// ops against an arithmetic model, Start filtering, back-to-back and async reset.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  muldiv_sequencer_if #(.WIDTH(32)) bus();
  muldiv_sequencer #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  // Reference: {dbz, hi, lo} from plain arithmetic on the MIPS op semantics
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'd1: begin q = sa * sb; p = q; return {1'b0, p}; end
      2'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        q = sa / sb; r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Called #1 after a posedge with the DUT idle; Start is sampled on the next edge (edge 1).
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int done_edge, output int ndone, output logic [31:0] hi,
                       output logic [31:0] lo, output logic dbz, output int busy_err,
                       output int dbz_err);
    done_edge = -1; ndone = 0; hi = 'x; lo = 'x; dbz = 1'b0; busy_err = 0; dbz_err = 0;
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    for (int e = 1; e <= 36; e++) begin
      @(posedge clk); #1;
      if (e == 1) bus.Start = 1'b0;
      if (bus.Busy !== ((e >= 1) && (e <= 34))) busy_err++;
      if (bus.Done === 1'b1) begin
        ndone++; done_edge = e; hi = bus.High; lo = bus.Low; dbz = bus.DivByZero;
      end else if (bus.DivByZero !== 1'b0) dbz_err++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.Start = 1'b0; bus.Op = '0; bus.A = '0; bus.B = '0;
    #1;
    checks++;
    if ({bus.Busy, bus.Done, bus.DivByZero, bus.High, bus.Low} !== 67'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b dbz=%b hi=%h lo=%h want all zero",
               bus.Busy, bus.Done, bus.DivByZero, bus.High, bus.Low);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    vec_t v[8];
    int de, nd, be, ze;
    logic [31:0] hi, lo;
    logic dbz;
    v[0] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    v[1] = '{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    v[2] = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    v[3] = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    v[4] = '{2'd2, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    v[5] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    v[6] = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    v[7] = '{2'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, de, nd, hi, lo, dbz, be, ze);
      checks++;
      if (de != 35 || nd != 1) begin
        failures++;
        $display("FAIL dir%0d_latency got done_edge=%0d count=%0d want 35 and 1", i, de, nd);
      end
      checks++;
      if (hi !== v[i].hi || lo !== v[i].lo || dbz !== v[i].dbz) begin
        failures++;
        $display("FAIL dir%0d_result got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                 i, hi, lo, dbz, v[i].hi, v[i].lo, v[i].dbz);
      end
      checks++;
      if (be != 0 || ze != 0) begin
        failures++;
        $display("FAIL dir%0d_flags got busy_errs=%0d dbz_errs=%0d want 0 and 0", i, be, ze);
      end
    end
  endtask

  task automatic test_random;
    int de, nd, be, ze;
    logic [31:0] a, b, hi, lo;
    logic [1:0] op;
    logic dbz;
    logic [64:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      exp = model(op, a, b);
      do_op(op, a, b, de, nd, hi, lo, dbz, be, ze);
      checks++;
      if (de != 35 || nd != 1 || be != 0 || ze != 0) begin
        failures++;
        $display("FAIL rand%0d_ctrl got done_edge=%0d count=%0d busy_errs=%0d dbz_errs=%0d want 35/1/0/0",
                 i, de, nd, be, ze);
      end
      checks++;
      if ({dbz, hi, lo} !== exp) begin
        failures++;
        $display("FAIL rand%0d_result op=%0d a=%h b=%h got dbz=%b hi=%h lo=%h want dbz=%b hi=%h lo=%h",
                 i, op, a, b, dbz, hi, lo, exp[64], exp[63:32], exp[31:0]);
      end
      repeat (2) @(posedge clk); #1;
      checks++;
      if ({bus.High, bus.Low} !== exp[63:0]) begin
        failures++;
        $display("FAIL rand%0d_hold got hi=%h lo=%h want hi=%h lo=%h",
                 i, bus.High, bus.Low, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int nd = 0, de = -1;
    logic [31:0] hi = 'x, lo = 'x;
    bus.Start = 1'b1; bus.Op = 2'd0; bus.A = 32'd6; bus.B = 32'd7;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clk); #1;
      if (e == 1) bus.Start = 1'b0;
      if (e == 9) begin bus.Start = 1'b1; bus.Op = 2'd2; bus.A = 32'd100; bus.B = 32'd7; end
      if (e == 10) bus.Start = 1'b0;
      if (bus.Done === 1'b1) begin nd++; de = e; hi = bus.High; lo = bus.Low; end
    end
    checks++;
    if (nd != 1 || de != 35) begin
      failures++;
      $display("FAIL ignore_start_done got count=%0d edge=%0d want 1 and 35", nd, de);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd42) begin
      failures++;
      $display("FAIL ignore_start_result got hi=%h lo=%h want hi=00000000 lo=0000002a", hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    int nd = 0;
    int de[2] = '{-1, -1};
    logic [31:0] hi[2], lo[2];
    bus.Start = 1'b1; bus.Op = 2'd0; bus.A = 32'd3; bus.B = 32'd9;
    for (int e = 1; e <= 75; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin bus.Op = 2'd1; bus.A = 32'hFFFFFFFE; bus.B = 32'd5; end
      if (e == 71) bus.Start = 1'b0;
      if (bus.Done === 1'b1) begin
        if (nd < 2) begin de[nd] = e; hi[nd] = bus.High; lo[nd] = bus.Low; end
        nd++;
      end
    end
    checks++;
    if (nd != 2 || de[0] != 35 || de[1] != 71) begin
      failures++;
      $display("FAIL b2b_timing got count=%0d edges=%0d,%0d want 2 at 35,71", nd, de[0], de[1]);
    end
    checks++;
    if (hi[0] !== 32'd0 || lo[0] !== 32'd27 || hi[1] !== 32'hFFFFFFFF || lo[1] !== 32'hFFFFFFF6) begin
      failures++;
      $display("FAIL b2b_result got %h:%h %h:%h want 00000000:0000001b ffffffff:fffffff6",
               hi[0], lo[0], hi[1], lo[1]);
    end
  endtask

  task automatic test_reset_midop;
    int de, nd, be, ze;
    logic [31:0] hi, lo;
    logic dbz;
    bus.Start = 1'b1; bus.Op = 2'd3; bus.A = 32'hFFFF0000; bus.B = 32'd3;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 1) bus.Start = 1'b0;
    end
    checks++;
    if (bus.Busy !== 1'b1 || {bus.High, bus.Low} === 64'd0) begin
      failures++;
      $display("FAIL midop_precond got busy=%b hi=%h lo=%h want busy=1 and nonzero result",
               bus.Busy, bus.High, bus.Low);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.Busy, bus.Done, bus.DivByZero, bus.High, bus.Low} !== 67'd0) begin
      failures++;
      $display("FAIL midop_async_reset got busy=%b done=%b dbz=%b hi=%h lo=%h want all zero",
               bus.Busy, bus.Done, bus.DivByZero, bus.High, bus.Low);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    do_op(2'd0, 32'd3, 32'd5, de, nd, hi, lo, dbz, be, ze);
    checks++;
    if (de != 35 || nd != 1 || hi !== 32'd0 || lo !== 32'd15 || dbz !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_op got edge=%0d count=%0d hi=%h lo=%h dbz=%b want 35 1 0 15 0",
               de, nd, hi, lo, dbz);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
